// File: rtl/miriscv_apb_gpio.sv
// rtl/miriscv_apb_gpio.sv - APB GPIO block with pin synchronizer and optional edge interrupts
//
// Purpose: APB register interface for up to 32 GPIO pins. It provides output value
//   and direction registers, set/clear aliases for OUT, and a 2-flop synchronized
//   view of the input pins.
// Optional feature: defining MIRISCV_APB_GPIO_IRQ_EN adds rising/falling edge
//   detection, the IRQ_EN/RISE/FALL/PEND registers and a registered level interrupt.
//   Without it, offsets 0x00C-0x018 are unmapped and irq_o is tied low.
// Ports:
//   clk_i, arstn_i        clock, asynchronous active-low reset
//   psel_i .. pslverr_o   APB responder (zero wait states, pready_o always 1)
//   gpio_i                asynchronous pin inputs
//   gpio_o, gpio_oe_o     output values and output enables (1 = drive)
//   irq_o                 level interrupt, |(PEND & IRQ_EN) registered
module miriscv_apb_gpio #(
  parameter int GPIO_W = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [11:0]       paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);

  // Word indices of paddr_i[11:2]
  localparam logic [9:0] REG_IN     = 10'd0;
  localparam logic [9:0] REG_OUT    = 10'd1;
  localparam logic [9:0] REG_DIR    = 10'd2;
  localparam logic [9:0] REG_IRQ_EN = 10'd3;
  localparam logic [9:0] REG_RISE   = 10'd4;
  localparam logic [9:0] REG_FALL   = 10'd5;
  localparam logic [9:0] REG_PEND   = 10'd6;
  localparam logic [9:0] REG_SET    = 10'd7;
  localparam logic [9:0] REG_CLR    = 10'd8;

  logic [9:0]        word;
  logic              access;
  logic              addr_err;
  logic              wr_en;
  logic [31:0]       rdata;
  logic [GPIO_W-1:0] wdata;

  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;
  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] dir_q, dir_d;

`ifdef MIRISCV_APB_GPIO_IRQ_EN
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] irq_en_q, irq_en_d;
  logic [GPIO_W-1:0] rise_q, rise_d;
  logic [GPIO_W-1:0] fall_q, fall_d;
  logic [GPIO_W-1:0] pend_q, pend_d;
  logic [GPIO_W-1:0] edge_hit;
  logic              irq_q;
`endif

  // Byte-lane bits of the address are ignored by the word decode
  logic unused_bits;
  assign unused_bits = ^{paddr_i[1:0], pwdata_i};

  assign word   = paddr_i[11:2];
  assign access = psel_i & penable_i;
  assign wdata  = pwdata_i[GPIO_W-1:0];

  // Address decode and read mux; an error also forces the read data to 0
  always_comb begin
    rdata    = '0;
    addr_err = 1'b0;
    case (word)
      REG_IN: begin
        rdata    = 32'(sync2_q);
        addr_err = pwrite_i;
      end
      REG_OUT: rdata = 32'(out_q);
      REG_DIR: rdata = 32'(dir_q);
`ifdef MIRISCV_APB_GPIO_IRQ_EN
      REG_IRQ_EN: rdata = 32'(irq_en_q);
      REG_RISE:   rdata = 32'(rise_q);
      REG_FALL:   rdata = 32'(fall_q);
      REG_PEND:   rdata = 32'(pend_q);
`endif
      REG_SET, REG_CLR: rdata = '0;
      default: addr_err = 1'b1;
    endcase
  end

  assign prdata_o  = (psel_i && !addr_err) ? rdata : '0;
  assign pready_o  = 1'b1;
  // Gated by reset so a bus access during reset never reports an error
  assign pslverr_o = access & addr_err & arstn_i;
  assign wr_en     = access & pwrite_i & ~addr_err;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_en) begin
      case (word)
        REG_OUT: out_d = wdata;
        REG_DIR: dir_d = wdata;
        REG_SET: out_d = out_q | wdata;
        REG_CLR: out_d = out_q & ~wdata;
        default: ;
      endcase
    end
  end

`ifdef MIRISCV_APB_GPIO_IRQ_EN
  // prev_q lags the synchronized value by one cycle; pins are watched
  // regardless of DIR so driven outputs loop back into edge detection
  assign edge_hit = (sync2_q & ~prev_q & rise_q) | (~sync2_q & prev_q & fall_q);

  always_comb begin
    irq_en_d = irq_en_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    pend_d   = pend_q;
    if (wr_en) begin
      case (word)
        REG_IRQ_EN: irq_en_d = wdata;
        REG_RISE:   rise_d   = wdata;
        REG_FALL:   fall_d   = wdata;
        REG_PEND:   pend_d   = pend_q & ~wdata;
        default: ;
      endcase
    end
    // Applied after the W1C so a same-cycle edge keeps its pending bit
    pend_d = pend_d | edge_hit;
  end
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      dir_q   <= '0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      dir_q   <= dir_d;
    end
  end

`ifdef MIRISCV_APB_GPIO_IRQ_EN
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      prev_q   <= '0;
      irq_en_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      prev_q   <= sync2_q;
      irq_en_q <= irq_en_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      irq_q    <= |(pend_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;

endmodule

// File: doc/miriscv_apb_gpio.md
MIRISCV_APB_GPIO -- requirements
Module: miriscv_apb_gpio

Interface
REQ-001 The module SHALL have parameter GPIO_W, default 32, giving the number of GPIO pins (1..32).
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port arstn_i, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The module SHALL have APB responder ports:
- psel_i, input, 1 bit
- penable_i, input, 1 bit
- pwrite_i, input, 1 bit
- paddr_i, input, 12 bits
- pwdata_i, input, 32 bits
- prdata_o, output, 32 bits
- pready_o, output, 1 bit
- pslverr_o, output, 1 bit
REQ-005 The module SHALL have pin ports:
- gpio_i, input, GPIO_W bits: asynchronous pin inputs
- gpio_o, output, GPIO_W bits: output values
- gpio_oe_o, output, GPIO_W bits: output enables (1 = drive)
REQ-006 The module SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-007 Access SHALL be psel_i & penable_i; pready_o SHALL be constant 1 (zero wait states); psel_i and penable_i asserted in the same cycle SHALL complete as one access.
REQ-008 prdata_o SHALL be combinational from paddr_i whenever psel_i=1, and 0 when psel_i=0.
REQ-009 A write SHALL take effect at the clock edge ending the access cycle; a read SHALL have no side effects.
REQ-010 The register map, decoded on paddr_i[11:2], SHALL be (unused upper bits read 0):
- 0x000 IN: read-only, synchronized pins
- 0x004 OUT: read/write
- 0x008 DIR: read/write, drives gpio_oe_o
- 0x00C IRQ_EN: read/write
- 0x010 RISE: read/write, rising-edge enable
- 0x014 FALL: read/write, falling-edge enable
- 0x018 PEND: read, write-1-to-clear
- 0x01C SET: write-only; OUT |= pwdata; reads 0
- 0x020 CLR: write-only; OUT &= ~pwdata; reads 0
REQ-011 An access to an unmapped offset, or a write to IN, SHALL assert pslverr_o in that cycle, return 0 and change no state; pslverr_o SHALL be 0 otherwise.
REQ-012 gpio_i SHALL pass through a 2-flop synchronizer; IN SHALL equal the second stage, so a pin change is visible in IN 2 cycles later.
REQ-013 A rise SHALL be defined as prev=0, sync=1, where prev is a third flop delayed from the second stage; a fall SHALL be the inverse.
REQ-014 A PEND bit SHALL be set in the cycle after a detected edge whose type is enabled in RISE/FALL.
REQ-015 If a PEND set and a W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-016 irq_o SHALL equal the registered |(PEND & IRQ_EN).
REQ-017 Edge detection SHALL be independent of DIR, so output pins loop back.

Reset
REQ-018 While arstn_i=0, the module SHALL clear all registers, synchronizer and prev flops.
REQ-019 During reset, gpio_o, gpio_oe_o and irq_o SHALL be 0; pready_o SHALL be 1 and pslverr_o SHALL be 0.
REQ-020 Reset asserted mid-access SHALL discard that access.
REQ-021 After reset, no edge SHALL be detected until two clock edges have elapsed following reset release.

Configuration
REQ-022 With macro MIRISCV_APB_GPIO_IRQ_EN defined, the module SHALL implement the edge detection, IRQ_EN, RISE, FALL and PEND registers, and irq_o as specified.
REQ-023 Without MIRISCV_APB_GPIO_IRQ_EN, the module SHALL omit that logic: offsets 0x00C-0x018 SHALL be treated as unmapped (pslverr_o=1, read 0) and irq_o SHALL be tied 0.

Verification
REQ-024 Reset, then read all offsets -> all read 0, gpio_oe_o=0, irq_o=0.
REQ-025 Write OUT=0x0000_00F0, then SET 0x0F, then CLR 0x30 -> OUT reads 0x0000_00CF and gpio_o=0xCF.
REQ-026 gpio_i[3] changes 0->1 at cycle t -> IN bit3=1 at t+2; with RISE[3]=1 and IRQ_EN[3]=1, PEND bit3 and irq_o go high by t+4.
REQ-027 W1C of PEND=0x8 in the same cycle a new rise on bit3 is detected -> PEND bit3 stays 1.
REQ-028 Read 0x024, then write IN -> pslverr_o=1, prdata_o=0, no state change; without MIRISCV_APB_GPIO_IRQ_EN, an access to 0x018 -> pslverr_o=1.
REQ-029 Assert arstn_i mid-write of DIR=0xFFFF_FFFF -> DIR reads 0 and gpio_oe_o=0 after reset release.
